// File: rtl/classification_scorer.sv
// classification_scorer: counts correct predictions over a run of test
// images and produces an integer accuracy percentage with a bit-serial
// restoring divider.
// Optional feature macro: SCORER_FIRST_MISS_EN adds first-miss capture ports.
module classification_scorer #(
  parameter int NUM_TESTS = 750,
  parameter int IDX_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       mnist_class,
  input  logic             single_test_done,
  input  logic             done,
  input  logic [3:0]       label,
  output logic [IDX_W-1:0] label_index,
  output logic [IDX_W-1:0] correct_count,
  output logic [IDX_W-1:0] test_count,
  output logic [6:0]       accuracy_pct,
  output logic             score_valid,
  output logic             busy
`ifdef SCORER_FIRST_MISS_EN
  ,
  output logic             first_miss_valid,
  output logic [IDX_W-1:0] first_miss_index,
  output logic [3:0]       first_miss_pred,
  output logic [3:0]       first_miss_label
`endif
);

  // Dividend is correct_count*100, which needs 7 extra bits over the counters.
  localparam int DVD_W = IDX_W + 7;
  localparam int CNT_W = $clog2(DVD_W + 1);
  localparam logic [IDX_W-1:0] MAX_CNT   = IDX_W'(NUM_TESTS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DVD_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DIV, DONE} state_t;

  state_t           state;
  logic [DVD_W-1:0] dvd;
  logic [IDX_W-1:0] rem;
  logic [CNT_W-1:0] step;

  // Counter increment that sticks at NUM_TESTS instead of wrapping.
  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (v >= MAX_CNT) ? MAX_CNT : v + IDX_W'(1);
  endfunction

  // Out-of-range class codes (10..15) never count as correct.
  logic hit;
  assign hit = (mnist_class == label) && (mnist_class <= 4'd9);

  logic [IDX_W-1:0] tcnt_nxt, corr_nxt, idx_nxt;
  logic             last_test;

  // Next counter values for the scored test, so the divider can be loaded
  // in the same cycle that the final test is counted.
  always_comb begin
    tcnt_nxt = test_count;
    corr_nxt = correct_count;
    idx_nxt  = label_index;
    if (single_test_done) begin
      tcnt_nxt = sat_inc(test_count);
      idx_nxt  = sat_inc(label_index);
      if (hit) corr_nxt = sat_inc(correct_count);
    end
  end

  assign last_test = single_test_done && (tcnt_nxt == MAX_CNT);

  logic [IDX_W:0]   trial, diff;
  logic             ge;
  logic [IDX_W-1:0] rem_step;
  logic [DVD_W-1:0] dvd_step;

  // One restoring-division step: the borrow bit of trial-divisor decides the
  // quotient bit, which shifts into the bottom of the dividend register.
  always_comb begin
    trial    = {rem, dvd[DVD_W-1]};
    diff     = trial - {1'b0, test_count};
    ge       = ~diff[IDX_W];
    rem_step = ge ? diff[IDX_W-1:0] : trial[IDX_W-1:0];
    dvd_step = {dvd[DVD_W-2:0], ge};
  end

  // Run control: clear on start, score in RUN, divide in DIV, hold in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      label_index   <= '0;
      correct_count <= '0;
      test_count    <= '0;
      accuracy_pct  <= '0;
      score_valid   <= 1'b0;
      busy          <= 1'b0;
      step          <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            label_index   <= '0;
            correct_count <= '0;
            test_count    <= '0;
            accuracy_pct  <= '0;
            score_valid   <= 1'b0;
            busy          <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          label_index   <= idx_nxt;
          test_count    <= tcnt_nxt;
          correct_count <= corr_nxt;
          if (done || last_test) begin
            dvd   <= DVD_W'(corr_nxt) * DVD_W'(100);
            rem   <= '0;
            step  <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          if (test_count == '0) begin
            accuracy_pct <= '0;
            score_valid  <= 1'b1;
            busy         <= 1'b0;
            state        <= DONE;
          end else begin
            dvd  <= dvd_step;
            rem  <= rem_step;
            step <= step + CNT_W'(1);
            // correct_count <= test_count bounds the quotient to 100.
            if (step == LAST_STEP) begin
              accuracy_pct <= dvd_step[6:0];
              score_valid  <= 1'b1;
              busy         <= 1'b0;
              state        <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCORER_FIRST_MISS_EN
  // Latch index, prediction and label of the first wrong test in a run.
  always_ff @(posedge clk) begin
    if (rst || (((state == IDLE) || (state == DONE)) && start)) begin
      first_miss_valid <= 1'b0;
      first_miss_index <= '0;
      first_miss_pred  <= '0;
      first_miss_label <= '0;
    end else if ((state == RUN) && single_test_done && !hit && !first_miss_valid) begin
      first_miss_valid <= 1'b1;
      first_miss_index <= label_index;
      first_miss_pred  <= mnist_class;
      first_miss_label <= label;
    end
  end
`endif

endmodule

// File: tb/tb_classification_scorer.sv
// Bench for classification_scorer: directed scenarios plus randomized runs,
// checked against a counting model of the scoring rules.
module tb_classification_scorer;

  localparam int IDX_W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, std, done;
  logic [3:0] mclass;
  logic [3:0] rom [0:1023];

  logic [3:0]       label_a, label_b;
  logic [IDX_W-1:0] idx_a, corr_a, tc_a, idx_b, corr_b, tc_b;
  logic [6:0]       acc_a, acc_b;
  logic             sv_a, busy_a, sv_b, busy_b;

  assign label_a = rom[idx_a];
  assign label_b = rom[idx_b];

`ifdef SCORER_FIRST_MISS_EN
  logic             fmv_a, fmv_b;
  logic [IDX_W-1:0] fmi_a, fmi_b;
  logic [3:0]       fmp_a, fmp_b, fml_a, fml_b;
`endif

  classification_scorer #(.NUM_TESTS(750), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mnist_class(mclass),
    .single_test_done(std), .done(done), .label(label_a),
    .label_index(idx_a), .correct_count(corr_a), .test_count(tc_a),
    .accuracy_pct(acc_a), .score_valid(sv_a), .busy(busy_a)
`ifdef SCORER_FIRST_MISS_EN
    , .first_miss_valid(fmv_a), .first_miss_index(fmi_a),
    .first_miss_pred(fmp_a), .first_miss_label(fml_a)
`endif
  );

  classification_scorer #(.NUM_TESTS(4), .IDX_W(IDX_W)) dut4 (
    .clk(clk), .rst(rst), .start(start), .mnist_class(mclass),
    .single_test_done(std), .done(done), .label(label_b),
    .label_index(idx_b), .correct_count(corr_b), .test_count(tc_b),
    .accuracy_pct(acc_b), .score_valid(sv_b), .busy(busy_b)
`ifdef SCORER_FIRST_MISS_EN
    , .first_miss_valid(fmv_b), .first_miss_index(fmi_b),
    .first_miss_pred(fmp_b), .first_miss_label(fml_b)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Model of one run: how many tests were scored, how many were right,
  // and where the first wrong one happened.
  int m_tests, m_corr, m_fm_idx, m_fm_pred, m_fm_label;
  bit m_fm_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; std = 1'b0; done = 1'b0; mclass = 4'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_tests = 0; m_corr = 0; m_fm_seen = 1'b0;
    m_fm_idx = 0; m_fm_pred = 0; m_fm_label = 0;
  endtask

  task automatic send(input int pred, input bit with_done);
    int lbl;
    lbl = int'(rom[m_tests]);
    mclass = 4'(pred); std = 1'b1; done = with_done;
    tick();
    std = 1'b0; done = 1'b0;
    if (pred == lbl && pred <= 9) m_corr++;
    else if (!m_fm_seen) begin
      m_fm_seen = 1'b1; m_fm_idx = m_tests; m_fm_pred = pred; m_fm_label = lbl;
    end
    m_tests++;
  endtask

  task automatic finish_run();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic wait_sv_a(input int budget);
    int n;
    n = 0;
    while (!sv_a && n < budget) begin
      tick();
      n++;
    end
    chk("score_valid_wait", 32'(sv_a), 32'd1);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_test_count"}, 32'(tc_a), 32'(m_tests));
    chk({tag, "_correct"}, 32'(corr_a), 32'(m_corr));
    chk({tag, "_label_index"}, 32'(idx_a), 32'(m_tests));
    chk({tag, "_accuracy"}, 32'(acc_a), (m_tests == 0) ? 32'd0 : 32'((m_corr * 100) / m_tests));
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
`ifdef SCORER_FIRST_MISS_EN
    chk({tag, "_fm_valid"}, 32'(fmv_a), 32'(m_fm_seen));
    if (m_fm_seen) begin
      chk({tag, "_fm_index"}, 32'(fmi_a), 32'(m_fm_idx));
      chk({tag, "_fm_pred"}, 32'(fmp_a), 32'(m_fm_pred));
      chk({tag, "_fm_label"}, 32'(fml_a), 32'(m_fm_label));
    end
`endif
  endtask

  initial begin
    int n, pred, cyc;
    bit dflag;

    for (int i = 0; i < 1024; i++) rom[i] = 4'($urandom_range(0, 9));

    // Reset state of both instances.
    do_reset();
    chk("rst_label_index", 32'(idx_a), 32'd0);
    chk("rst_correct", 32'(corr_a), 32'd0);
    chk("rst_test_count", 32'(tc_a), 32'd0);
    chk("rst_accuracy", 32'(acc_a), 32'd0);
    chk("rst_score_valid", 32'(sv_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst4_test_count", 32'(tc_b), 32'd0);
    chk("rst4_score_valid", 32'(sv_b), 32'd0);

    // Four tests with NUM_TESTS=4: labels 3,7,1,9, predictions 3,7,2,9.
    rom[0] = 4'd3; rom[1] = 4'd7; rom[2] = 4'd1; rom[3] = 4'd9;
    start_run();
    chk("run_busy", 32'(busy_b), 32'd1);
    send(3, 1'b0); send(7, 1'b0); send(2, 1'b0); send(9, 1'b0);
    chk("n4_test_count", 32'(tc_b), 32'd4);
    chk("n4_correct", 32'(corr_b), 32'd3);
    chk("n4_div_busy", 32'(busy_b), 32'd1);
    chk("n4_div_not_valid", 32'(sv_b), 32'd0);
    chk("n4_div_acc_held", 32'(acc_b), 32'd0);
    chk("n750_still_running", 32'(busy_a), 32'd1);
    cyc = 0;
    while (!sv_b && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("n4_div_cycles", 32'(cyc), 32'd17);
    chk("n4_accuracy", 32'(acc_b), 32'd75);
    chk("n4_busy_after", 32'(busy_b), 32'd0);

    // done with no tests scored: accuracy 0, valid two cycles after done.
    do_reset();
    start_run();
    finish_run();
    chk("zero_div_busy", 32'(busy_a), 32'd1);
    chk("zero_div_not_valid", 32'(sv_a), 32'd0);
    tick();
    chk("zero_valid", 32'(sv_a), 32'd1);
    chk("zero_accuracy", 32'(acc_a), 32'd0);
    chk("zero_test_count", 32'(tc_a), 32'd0);

    // Restart from DONE; done coincides with the second (correct) test.
    start_run();
    chk("restart_cleared_valid", 32'(sv_a), 32'd0);
    chk("restart_busy", 32'(busy_a), 32'd1);
    send(int'(rom[0]), 1'b0);
    send(int'(rom[1]), 1'b1);
    chk("coinc_test_count", 32'(tc_a), 32'd2);
    wait_sv_a(40);
    chk("coinc_accuracy", 32'(acc_a), 32'd100);
    check_model("coinc");

    // start ignored in RUN and DIV; reset in the middle of DIV.
    do_reset();
    start_run();
    for (int i = 0; i < 3; i++) send(($urandom_range(0, 1) != 0) ? int'(rom[i]) : 15, 1'b0);
    start = 1'b1;
    send(int'(rom[3]), 1'b0);
    start = 1'b0;
    chk("start_in_run_test_count", 32'(tc_a), 32'(m_tests));
    chk("start_in_run_correct", 32'(corr_a), 32'(m_corr));
    chk("start_in_run_busy", 32'(busy_a), 32'd1);
    finish_run();
    start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    start = 1'b0;
    chk("start_in_div_busy", 32'(busy_a), 32'd1);
    chk("start_in_div_valid", 32'(sv_a), 32'd0);
    chk("start_in_div_test_count", 32'(tc_a), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_label_index", 32'(idx_a), 32'd0);
    chk("midrst_correct", 32'(corr_a), 32'd0);
    chk("midrst_test_count", 32'(tc_a), 32'd0);
    chk("midrst_accuracy", 32'(acc_a), 32'd0);
    chk("midrst_valid", 32'(sv_a), 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    tick(); tick();
    chk("idle_waits_busy", 32'(busy_a), 32'd0);
    chk("idle_waits_valid", 32'(sv_a), 32'd0);

    // Out-of-range class 12 never scores; first miss at index 5.
    for (int i = 0; i < 10; i++) rom[i] = 4'($urandom_range(0, 9));
    rom[5] = 4'd8; rom[7] = 4'd12;
    start_run();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) pred = 4;
      else if (i == 6) pred = (int'(rom[6]) + 1) % 10;
      else if (i == 7) pred = 12;
      else pred = int'(rom[i]);
      send(pred, 1'b0);
    end
    chk("cls12_correct", 32'(corr_a), 32'd7);
    finish_run();
    wait_sv_a(40);
    chk("cls12_accuracy", 32'(acc_a), 32'd70);
`ifdef SCORER_FIRST_MISS_EN
    chk("fm_index5", 32'(fmi_a), 32'd5);
    chk("fm_pred4", 32'(fmp_a), 32'd4);
    chk("fm_label8", 32'(fml_a), 32'd8);
`endif
    check_model("cls12");

    // Full 750-test run, every third test wrong, random gaps.
    for (int i = 0; i < 750; i++) rom[i] = 4'($urandom_range(0, 9));
    do_reset();
    start_run();
`ifdef SCORER_FIRST_MISS_EN
    chk("fm_cleared_on_start", 32'(fmv_a), 32'd0);
`endif
    for (int i = 0; i < 750; i++) begin
      if (i % 3 == 2)
        pred = ($urandom_range(0, 1) != 0) ? (int'(rom[i]) + 1 + int'($urandom_range(0, 8))) % 10
                                           : int'($urandom_range(10, 15));
      else
        pred = int'(rom[i]);
      send(pred, 1'b0);
      n = int'($urandom_range(0, 2));
      if (i != 749) for (int k = 0; k < n; k++) tick();
    end
    chk("full_test_count", 32'(tc_a), 32'd750);
    chk("full_correct", 32'(corr_a), 32'd500);
    chk("full_auto_div", 32'(busy_a), 32'd1);
    wait_sv_a(40);
    chk("full_accuracy", 32'(acc_a), 32'd66);
    check_model("full");
    send(0, 1'b0);
    chk("full_saturated", 32'(tc_a), 32'd750);

    // Randomized runs, labels include out-of-range codes.
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) rom[i] = 4'($urandom_range(0, 15));
      start_run();
      for (int i = 0; i < n; i++) begin
        pred = ($urandom_range(0, 2) != 0) ? int'(rom[i]) : int'($urandom_range(0, 15));
        dflag = (i == n - 1) && ($urandom_range(0, 1) != 0);
        send(pred, dflag);
        if (!dflag && $urandom_range(0, 3) == 0) tick();
      end
      if (busy_a && !(tc_a == 10'(n) && sv_a)) begin
        if (!dflag) finish_run();
      end
      wait_sv_a(40);
      check_model($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
